// File: rtl/weight_pkg.sv
// Shared types for the weight loader: FSM encoding and default geometry of the weight medium.
package weight_pkg;

    localparam int ADDRS      = 256;
    localparam int BRAM_WIDTH = 64;
    localparam int PIECES     = 48;
    localparam int ADDR_SIZE  = $clog2(ADDRS);
    localparam int WIDTH      = PIECES * BRAM_WIDTH;

    typedef logic [ADDR_SIZE-1:0] weight_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATHER = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/weight_loader_chunk_buffer.sv
// One weight word assembled from / split into BRAM_WIDTH-bit pieces, with a shared piece pointer.
module chunk_buffer #(
    parameter int BRAM_WIDTH = 64,
    parameter int PIECES     = 48,
    localparam int WW        = PIECES * BRAM_WIDTH,
    localparam int IW        = (PIECES > 1) ? $clog2(PIECES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  put,
    input  logic [BRAM_WIDTH-1:0] put_data,
    input  logic                  load,
    input  logic [WW-1:0]         load_data,
    input  logic                  take,
    output logic [WW-1:0]         word,
    output logic [BRAM_WIDTH-1:0] piece,
    output logic                  last
);

    logic [IW-1:0] idx;

    assign last  = (idx == IW'(PIECES - 1));
    assign piece = word[idx*BRAM_WIDTH +: BRAM_WIDTH];

    // The pointer wraps to 0 after the last piece so the next word starts at the LSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= load_data;
            idx  <= '0;
        end else begin
            if (put)
                word[idx*BRAM_WIDTH +: BRAM_WIDTH] <= put_data;
            if (put || take)
                idx <= last ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams weight words between the host link and the weight medium (load = stream->medium, dump = medium->stream).
module weight_loader
    import weight_pkg::*;
#(
    parameter int ADDRS      = 256,
    parameter int BRAM_WIDTH = 64,
    parameter int PIECES     = 48,
    localparam int AW        = $clog2(ADDRS),
    localparam int WW        = PIECES * BRAM_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [AW-1:0]         cmd_base,
    input  logic [AW:0]           cmd_count,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BRAM_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BRAM_WIDTH-1:0] out_data,
    output logic [AW-1:0]         med_addr,
    output logic [WW-1:0]         med_wdata,
    output logic                  med_we,
    input  logic [WW-1:0]         med_rdata,
    input  logic                  med_finished,
    output logic                  busy_out,
    output logic                  done_out
);

    loader_state_t state;
    logic [AW-1:0] addr;
    logic [AW:0]   remain;
    logic          is_write;
    logic          piece_last;
    logic [AW:0]   count_clamped;
    logic [AW-1:0] addr_next;
    logic          last_word;

    assign count_clamped = (cmd_count > (AW+1)'(ADDRS)) ? (AW+1)'(ADDRS) : cmd_count;
    assign addr_next     = (addr == AW'(ADDRS - 1)) ? '0 : addr + AW'(1);
    assign last_word     = (remain == (AW+1)'(1));

    assign cmd_ready = (state == ST_IDLE);
    assign busy_out  = (state != ST_IDLE);
    assign done_out  = (state == ST_DONE);
    assign in_ready  = (state == ST_GATHER);
    assign out_valid = (state == ST_EMIT);
    assign med_addr  = addr;
    assign med_we    = is_write && ((state == ST_REQ) || (state == ST_WAIT));

    chunk_buffer #(
        .BRAM_WIDTH (BRAM_WIDTH),
        .PIECES     (PIECES)
    ) u_buf (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .put       (in_ready && in_valid),
        .put_data  (in_data),
        .load      ((state == ST_WAIT) && med_finished && !is_write),
        .load_data (med_rdata),
        .take      (out_valid && out_ready),
        .word      (med_wdata),
        .piece     (out_data),
        .last      (piece_last)
    );

    // REQ never looks at med_finished: it may still be high from the previous request.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= ST_IDLE;
            addr     <= '0;
            remain   <= '0;
            is_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    addr     <= cmd_base;
                    remain   <= count_clamped;
                    is_write <= cmd_write;
                    if (count_clamped == '0) state <= ST_DONE;
                    else state <= cmd_write ? ST_GATHER : ST_REQ;
                end
                ST_GATHER: if (in_valid && piece_last) state <= ST_REQ;
                ST_REQ:    state <= ST_WAIT;
                ST_WAIT: if (med_finished) begin
                    if (is_write) begin
                        remain <= remain - (AW+1)'(1);
                        addr   <= addr_next;
                        state  <= last_word ? ST_DONE : ST_GATHER;
                    end else begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: if (out_ready && piece_last) begin
                    remain <= remain - (AW+1)'(1);
                    addr   <= addr_next;
                    state  <= last_word ? ST_DONE : ST_REQ;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a behavioural medium answering 5 cycles after each request.
module tb_weight_loader;
    import weight_pkg::*;

    localparam int ADDRS = 4;
    localparam int BW    = 8;
    localparam int PC    = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_base;
    logic [2:0]  cmd_count;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [1:0]  med_addr;
    logic [23:0] med_wdata, med_rdata;
    logic        med_we, med_finished;
    logic        busy_out, done_out;

    weight_loader #(.ADDRS(ADDRS), .BRAM_WIDTH(BW), .PIECES(PC)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .med_addr(med_addr), .med_wdata(med_wdata), .med_we(med_we),
        .med_rdata(med_rdata), .med_finished(med_finished),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural medium: a request is the loader's REQ cycle; finished rises 5 cycles later.
    logic [23:0] mem [4];
    logic        fin_reg = 1'b0;
    logic        force_fin = 1'b0;
    int          mcnt = 0;
    int          req_cnt = 0;
    wire         med_req = (dut.state == ST_REQ);

    assign med_finished = fin_reg | force_fin;
    assign med_rdata    = mem[med_addr];

    always @(posedge clk_in) begin
        if (med_req) begin
            mcnt    <= 1;
            fin_reg <= 1'b0;
            req_cnt <= req_cnt + 1;
        end else if (mcnt != 0) begin
            if (mcnt == 4) begin
                fin_reg <= 1'b1;
                mcnt    <= 0;
                if (med_we) mem[med_addr] <= med_wdata;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    // Output-ready pattern driver.
    logic rdy_toggle = 1'b0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    initial begin
        int pidx;
        pidx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            if (rdy_toggle) begin
                out_ready = pat[pidx];
                pidx = (pidx + 1) % 4;
            end else begin
                out_ready = 1'b1;
                pidx = 0;
            end
        end
    end

    // Monitors sampled on the falling edge.
    int         we_bad = 0, stall_bad = 0, done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] outq [$];
    always @(negedge clk_in) begin
        if (med_we && (in_ready || out_valid || done_out || cmd_ready)) we_bad++;
        if (done_out) done_cnt++;
        if (prev_stall && (!out_valid || out_data != prev_data)) stall_bad++;
        if (out_valid && out_ready) outq.push_back(out_data);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] base, input logic [2:0] cnt);
        cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_count = cnt;
        @(posedge clk_in);
        @(negedge clk_in);
        cmd_valid = 1'b0;
    endtask

    task automatic send_chunk(input logic [7:0] d);
        int t;
        t = 0;
        in_valid = 1'b1; in_data = d;
        while (!in_ready && t < 200) begin @(negedge clk_in); t++; end
        if (t >= 200) chk("in_ready_timeout", 0, 1);
        @(posedge clk_in);
        @(negedge clk_in);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int k = 0; k < PC; k++) send_chunk(w[k*8 +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done_out && t < 400) begin @(negedge clk_in); t++; end
        chk(tag, t < 400, 1);
        @(negedge clk_in);
    endtask

    task automatic chk_dump(input string tag, input logic [7:0] e [$]);
        chk({tag, "_len"}, outq.size(), e.size());
        for (int i = 0; i < e.size() && i < outq.size(); i++)
            chk($sformatf("%s_%0d", tag, i), outq[i], e[i]);
    endtask

    initial begin
        int dc;
        int rc;
        rst_in = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_count = '0;
        in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy_out, 0);
        chk("rst_outs", {done_out, in_ready, out_valid, med_we}, 0);
        chk("rst_med", {med_addr, med_wdata}, 0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Load two words starting at address 1.
        dc = done_cnt;
        issue(1'b1, 2'd1, 3'd2);
        send_word(24'h332211);
        send_word(24'h665544);
        wait_done("load_done_timeout");
        chk("load_addr1", mem[1], 24'h332211);
        chk("load_addr2", mem[2], 24'h665544);
        chk("load_done_pulses", done_cnt - dc, 1);

        // Dump across the address wrap 3 -> 0.
        mem[3] = 24'hCCBBAA;
        mem[0] = 24'h030201;
        outq.delete();
        issue(1'b0, 2'd3, 3'd2);
        wait_done("dump_wrap_timeout");
        chk_dump("dump_wrap", '{8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02, 8'h03});

        // Dump with a stalling consumer.
        outq.delete();
        rdy_toggle = 1'b1;
        issue(1'b0, 2'd1, 3'd2);
        wait_done("dump_stall_timeout");
        rdy_toggle = 1'b0;
        chk_dump("dump_stall", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        chk("stall_stable", stall_bad, 0);

        // Zero-length command.
        rc = req_cnt;
        issue(1'b1, 2'd2, 3'd0);
        chk("zero_done", done_out, 1);
        chk("zero_in_ready", in_ready, 0);
        @(negedge clk_in);
        chk("zero_done_gone", done_out, 0);
        chk("zero_idle", cmd_ready, 1);
        chk("zero_no_req", req_cnt - rc, 0);

        // Stale finished held through the REQ cycle of a write.
        force_fin = 1'b1;
        issue(1'b1, 2'd0, 3'd1);
        send_word(24'h090807);
        @(posedge clk_in);
        #1 force_fin = 1'b0;
        @(negedge clk_in);
        chk("stale_still_writing", med_we, 1);
        chk("stale_no_early_write", mem[0], 24'h030201);
        wait_done("stale_done_timeout");
        chk("stale_write", mem[0], 24'h090807);

        // Reset in the middle of gathering a word.
        issue(1'b1, 2'd2, 3'd1);
        send_chunk(8'hEE);
        send_chunk(8'hDD);
        rst_in = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_busy", busy_out, 0);
        chk("midrst_med_wdata", med_wdata, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        issue(1'b1, 2'd2, 3'd1);
        send_word(24'h030201);
        wait_done("midrst_done_timeout");
        chk("midrst_reload", mem[2], 24'h030201);

        // Count above ADDRS is clamped to ADDRS.
        outq.delete();
        dc = done_cnt;
        issue(1'b0, 2'd0, 3'd5);
        wait_done("clamp_timeout");
        chk_dump("clamp", '{8'h07, 8'h08, 8'h09, 8'h11, 8'h22, 8'h33,
                           8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC});
        chk("clamp_done_pulses", done_cnt - dc, 1);

        chk("we_outside_req_wait", we_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
